// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/
// write-back and drives ALU op, operand muxes and datapath enables.
module mips_mc_control #(
  parameter bit IMEM_WAIT_OK = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [4:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JR       = 4'd11
  } state_t;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_SUB  = 5'h02;
  localparam logic [4:0] OP_AND  = 5'h03;
  localparam logic [4:0] OP_OR   = 5'h04;
  localparam logic [4:0] OP_XOR  = 5'h05;
  localparam logic [4:0] OP_NOR  = 5'h06;
  localparam logic [4:0] OP_BGTZ = 5'h07;
  localparam logic [4:0] OP_LUI  = 5'h08;
  localparam logic [4:0] OP_SLL  = 5'h09;
  localparam logic [4:0] OP_JUMP = 5'h10;
  localparam logic [4:0] OP_BNE  = 5'h11;
  localparam logic [4:0] OP_BEQ  = 5'h12;
  localparam logic [4:0] OP_SLLV = 5'h13;
  localparam logic [4:0] OP_SRL  = 5'h14;
  localparam logic [4:0] OP_SRLV = 5'h15;
  localparam logic [4:0] OP_BLTZ = 5'h16;
  localparam logic [4:0] OP_BGEZ = 5'h17;

  state_t r_state;
  state_t w_next;

  logic       w_rdy;
  logic       w_rtype;
  logic [4:0] w_r_op;
  logic       w_r_ok;
  logic       w_shamt;
  logic       w_jr;
  logic [4:0] w_i_op;
  logic       w_i_ok;
  logic       w_i_zx;
  logic       w_lw;
  logic       w_sw;
  logic [4:0] w_br_op;
  logic       w_br_ok;
  logic       w_j;

  assign w_rdy   = IMEM_WAIT_OK ? mem_ready : 1'b1;
  assign w_rtype = (opcode == 6'h00);
  assign w_jr    = w_rtype && (funct == 6'h08);
  assign w_lw    = (opcode == 6'h23);
  assign w_sw    = (opcode == 6'h2B);
  assign w_j     = (opcode == 6'h02) ||
                   (opcode == 6'h03);
  assign state   = r_state;

  always_comb begin
    w_r_op  = OP_NOP;
    w_r_ok  = 1'b1;
    w_shamt = 1'b0;
    case (funct)
      6'h20, 6'h21: w_r_op = OP_ADD;
      6'h22, 6'h23: w_r_op = OP_SUB;
      6'h24: w_r_op = OP_AND;
      6'h25: w_r_op = OP_OR;
      6'h26: w_r_op = OP_XOR;
      6'h27: w_r_op = OP_NOR;
      6'h00: begin
        w_r_op  = OP_SLL;
        w_shamt = 1'b1;
      end
      6'h02: begin
        w_r_op  = OP_SRL;
        w_shamt = 1'b1;
      end
      6'h04: w_r_op = OP_SLLV;
      6'h06: w_r_op = OP_SRLV;
      default: w_r_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_i_op  = OP_NOP;
    w_i_ok  = 1'b1;
    w_i_zx  = 1'b0;
    w_br_op = OP_NOP;
    w_br_ok = 1'b0;
    case (opcode)
      6'h08, 6'h09: w_i_op = OP_ADD;
      6'h0C: begin
        w_i_op = OP_AND;
        w_i_zx = 1'b1;
      end
      6'h0D: begin
        w_i_op = OP_OR;
        w_i_zx = 1'b1;
      end
      6'h0E: begin
        w_i_op = OP_XOR;
        w_i_zx = 1'b1;
      end
      6'h0F: w_i_op = OP_LUI;
      default: w_i_ok = 1'b0;
    endcase
    case (opcode)
      6'h04: begin
        w_br_op = OP_BEQ;
        w_br_ok = 1'b1;
      end
      6'h05: begin
        w_br_op = OP_BNE;
        w_br_ok = 1'b1;
      end
      6'h07: begin
        w_br_op = OP_BGTZ;
        w_br_ok = 1'b1;
      end
      6'h01: begin
        if (rt == 5'd0) begin
          w_br_op = OP_BLTZ;
          w_br_ok = 1'b1;
        end else if (rt == 5'd1) begin
          w_br_op = OP_BGEZ;
          w_br_ok = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Reset gates every output to zero, aborting any in-flight write.
  always_comb begin
    alu_op     = OP_NOP;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    ext_zero   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    retire     = 1'b0;
    illegal    = 1'b0;
    w_next     = S_FETCH;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          alu_op    = OP_ADD;
          if (w_rdy) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            w_next   = S_DECODE;
          end else begin
            w_next = S_FETCH;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          alu_op    = OP_ADD;
          unique case (1'b1)
            w_rtype && w_r_ok: w_next = S_EXEC_R;
            w_jr:              w_next = S_JR;
            w_i_ok:            w_next = S_EXEC_I;
            w_lw || w_sw:      w_next = S_MEM_ADDR;
            w_br_ok:           w_next = S_BRANCH;
            w_j:               w_next = S_JUMP;
            default: begin
              illegal = 1'b1;
              retire  = 1'b1;
              w_next  = S_FETCH;
            end
          endcase
        end
        S_EXEC_R: begin
          alu_op = w_r_op;
          if (w_shamt) begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
          end else begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b00;
          end
          w_next = S_ALU_WB;
        end
        S_EXEC_I: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          alu_op    = w_i_op;
          ext_zero  = w_i_zx;
          w_next    = S_ALU_WB;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = w_rtype ? 2'b01 : 2'b00;
          retire    = 1'b1;
          w_next    = S_FETCH;
        end
        S_MEM_ADDR: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          alu_op    = OP_ADD;
          w_next    = w_lw ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          w_next   = w_rdy ? S_MEM_WB : S_MEM_RD;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
          retire     = 1'b1;
          w_next     = S_FETCH;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          retire    = w_rdy;
          w_next    = w_rdy ? S_FETCH : S_MEM_WR;
        end
        S_BRANCH: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b00;
          alu_op    = w_br_op;
          pc_src    = 2'b01;
          pc_write  = zero;
          retire    = 1'b1;
          w_next    = S_FETCH;
        end
        S_JUMP: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
          alu_op   = OP_JUMP;
          retire   = 1'b1;
          if (opcode == 6'h03) begin
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end
          w_next = S_FETCH;
        end
        S_JR: begin
          pc_src   = 2'b11;
          pc_write = 1'b1;
          alu_op   = OP_JUMP;
          retire   = 1'b1;
          w_next   = S_FETCH;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: per-cycle expectations built from
// instruction-level step lists, random instruction stream.
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic [4:0] rt = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [4:0] alu_op;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_zero;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       retire;
  logic       illegal;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_mc_control #(.IMEM_WAIT_OK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .opcode(opcode), .funct(funct), .rt(rt),
    .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_zero(ext_zero),
    .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .retire(retire),
    .illegal(illegal), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic [4:0] op;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       ez;
    logic       iod;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       rw;
    logic [1:0] rd;
    logic [1:0] m2r;
    logic       ret;
    logic       il;
  } exp_t;

  typedef struct packed {
    logic [5:0] opc;
    logic [5:0] fn;
    logic [4:0] r;
    logic       rdy;
    logic       z;
    exp_t       e;
  } cyc_t;

  typedef enum {
    C_ILL, C_R, C_SH, C_JR, C_I,
    C_LW, C_SW, C_BR, C_J, C_JAL
  } cls_t;

  exp_t obs;
  cyc_t q[$];
  int n_assert = 0;
  int n_fail = 0;
  logic [5:0] g_o;
  logic [5:0] g_f;
  logic [4:0] g_r;

  always_comb begin
    obs = '{st: state, op: alu_op,
            sa: alu_src_a, sb: alu_src_b,
            ez: ext_zero, iod: i_or_d,
            mr: mem_read, mw: mem_write,
            irw: ir_write, pcw: pc_write,
            pcs: pc_src, rw: reg_write,
            rd: reg_dst, m2r: mem_to_reg,
            ret: retire, il: illegal};
  end

  function automatic cls_t classify(
    input logic [5:0] o, input logic [5:0] f,
    input logic [4:0] r);
    case (o)
      6'h00: case (f)
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
        6'h25, 6'h26, 6'h27, 6'h04, 6'h06:
          return C_R;
        6'h00, 6'h02: return C_SH;
        6'h08: return C_JR;
        default: return C_ILL;
      endcase
      6'h08, 6'h09, 6'h0C, 6'h0D,
      6'h0E, 6'h0F: return C_I;
      6'h23: return C_LW;
      6'h2B: return C_SW;
      6'h04, 6'h05, 6'h07: return C_BR;
      6'h01: return (r <= 5'd1) ? C_BR : C_ILL;
      6'h02: return C_J;
      6'h03: return C_JAL;
      default: return C_ILL;
    endcase
  endfunction

  // ALU code table keyed by instruction encoding.
  function automatic logic [4:0] aop(
    input logic [5:0] o, input logic [5:0] f,
    input logic [4:0] r);
    if (o == 6'h00) begin
      case (f)
        6'h20, 6'h21: return 5'h01;
        6'h22, 6'h23: return 5'h02;
        6'h24: return 5'h03;
        6'h25: return 5'h04;
        6'h26: return 5'h05;
        6'h27: return 5'h06;
        6'h00: return 5'h09;
        6'h02: return 5'h14;
        6'h04: return 5'h13;
        6'h06: return 5'h15;
        default: return 5'h00;
      endcase
    end
    case (o)
      6'h08, 6'h09: return 5'h01;
      6'h0C: return 5'h03;
      6'h0D: return 5'h04;
      6'h0E: return 5'h05;
      6'h0F: return 5'h08;
      6'h04: return 5'h12;
      6'h05: return 5'h11;
      6'h07: return 5'h07;
      6'h01: return (r == 5'd0) ? 5'h16 : 5'h17;
      default: return 5'h00;
    endcase
  endfunction

  function automatic exp_t blank(input logic [3:0] s);
    exp_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input exp_t e, input logic rdy,
                      input logic z);
    cyc_t c;
    c.opc = g_o;
    c.fn  = g_f;
    c.r   = g_r;
    c.rdy = rdy;
    c.z   = z;
    c.e   = e;
    q.push_back(c);
  endtask

  task automatic gen(input logic [5:0] o, input logic [5:0] f,
                     input logic [4:0] r, input logic z,
                     input int sf, input int sm);
    exp_t e;
    cls_t c;
    logic [4:0] a;
    c = classify(o, f, r);
    a = aop(o, f, r);
    g_o = o;
    g_f = f;
    g_r = r;
    for (int i = 0; i < sf; i++) begin
      e = blank(4'd0);
      e.mr = 1'b1; e.sb = 2'b01; e.op = 5'h01;
      push(e, 1'b0, rbit());
    end
    e = blank(4'd0);
    e.mr = 1'b1; e.sb = 2'b01; e.op = 5'h01;
    e.irw = 1'b1; e.pcw = 1'b1;
    push(e, 1'b1, rbit());
    e = blank(4'd1);
    e.sb = 2'b11; e.op = 5'h01;
    if (c == C_ILL) begin
      e.il = 1'b1; e.ret = 1'b1;
      push(e, rbit(), rbit());
      return;
    end
    push(e, rbit(), rbit());
    case (c)
      C_R, C_SH, C_I: begin
        e = blank((c == C_I) ? 4'd3 : 4'd2);
        e.op = a;
        if (c == C_SH) begin
          e.sa = 2'b10; e.sb = 2'b10;
        end else if (c == C_R) begin
          e.sa = 2'b01; e.sb = 2'b00;
        end else begin
          e.sa = 2'b01; e.sb = 2'b10;
          e.ez = (o == 6'h0C || o == 6'h0D ||
                  o == 6'h0E);
        end
        push(e, rbit(), rbit());
        e = blank(4'd8);
        e.rw = 1'b1; e.ret = 1'b1;
        e.rd = (c == C_I) ? 2'b00 : 2'b01;
        push(e, rbit(), rbit());
      end
      C_LW, C_SW: begin
        e = blank(4'd4);
        e.sa = 2'b01; e.sb = 2'b10; e.op = 5'h01;
        push(e, rbit(), rbit());
        e = blank((c == C_LW) ? 4'd5 : 4'd7);
        e.iod = 1'b1;
        if (c == C_LW) e.mr = 1'b1;
        else e.mw = 1'b1;
        for (int i = 0; i < sm; i++)
          push(e, 1'b0, rbit());
        if (c == C_SW) e.ret = 1'b1;
        push(e, 1'b1, rbit());
        if (c == C_LW) begin
          e = blank(4'd6);
          e.rw = 1'b1; e.m2r = 2'b01; e.ret = 1'b1;
          push(e, rbit(), rbit());
        end
      end
      C_BR: begin
        e = blank(4'd9);
        e.sa = 2'b01; e.sb = 2'b00; e.op = a;
        e.pcs = 2'b01; e.pcw = z; e.ret = 1'b1;
        push(e, rbit(), z);
      end
      C_J, C_JAL: begin
        e = blank(4'd10);
        e.pcs = 2'b10; e.pcw = 1'b1;
        e.op = 5'h10; e.ret = 1'b1;
        if (c == C_JAL) begin
          e.rw = 1'b1; e.rd = 2'b10; e.m2r = 2'b10;
        end
        push(e, rbit(), rbit());
      end
      C_JR: begin
        e = blank(4'd11);
        e.pcs = 2'b11; e.pcw = 1'b1;
        e.op = 5'h10; e.ret = 1'b1;
        push(e, rbit(), rbit());
      end
      default: ;
    endcase
  endtask

  task automatic check(input exp_t o, input exp_t e,
                       input string tag);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, o, e);
    end
  endtask

  task automatic run_q(input string tag);
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      rst_n     = 1'b1;
      opcode    = c.opc;
      funct     = c.fn;
      rt        = c.r;
      mem_ready = c.rdy;
      zero      = c.z;
      #1;
      check(obs, c.e, $sformatf("%s st%0d", tag, c.e.st));
    end
  endtask

  logic [5:0] opt [21] = '{
    6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D,
    6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h07,
    6'h01, 6'h01, 6'h02, 6'h03, 6'h3F, 6'h06, 6'h10};
  logic [5:0] fnt [17] = '{
    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
    6'h27, 6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h08,
    6'h01, 6'h3F, 6'h05};

  initial begin
    logic [5:0] o;
    logic [5:0] f;
    logic [4:0] r;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      opcode    = 6'($urandom);
      funct     = 6'($urandom);
      mem_ready = rbit();
      zero      = rbit();
      #1;
      check(obs, blank(4'd0), "reset");
    end

    gen(6'h00, 6'h20, 5'd2, 1'b0, 0, 0);
    run_q("add");
    gen(6'h23, 6'h00, 5'd3, 1'b0, 0, 3);
    run_q("lw_stall");
    gen(6'h04, 6'h00, 5'd2, 1'b1, 0, 0);
    run_q("beq_taken");
    gen(6'h05, 6'h00, 5'd2, 1'b0, 0, 0);
    run_q("bne_not");
    gen(6'h00, 6'h00, 5'd1, 1'b0, 0, 0);
    run_q("sll");
    gen(6'h0D, 6'h11, 5'd4, 1'b0, 2, 0);
    run_q("ori");
    gen(6'h03, 6'h00, 5'd0, 1'b0, 0, 0);
    run_q("jal");
    gen(6'h00, 6'h08, 5'd0, 1'b0, 0, 0);
    run_q("jr");
    gen(6'h3F, 6'h00, 5'd0, 1'b0, 0, 0);
    run_q("illegal");
    gen(6'h01, 6'h00, 5'd2, 1'b1, 0, 0);
    run_q("regimm_rt2");

    for (int k = 0; k < 200; k++) begin
      o = opt[$urandom_range(0, 20)];
      f = fnt[$urandom_range(0, 16)];
      r = (o == 6'h01) ? 5'($urandom_range(0, 2))
                       : 5'($urandom);
      gen(o, f, r, rbit(), $urandom_range(0, 3),
          $urandom_range(0, 3));
      run_q("rand");
    end

    gen(6'h2B, 6'h00, 5'd1, 1'b0, 0, 5);
    while (q.size() > 5) void'(q.pop_back());
    run_q("sw_pre_reset");
    @(negedge clk);
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    #1;
    check(obs, blank(4'd7), "sw_reset_abort");
    gen(6'h00, 6'h25, 5'd1, 1'b0, 0, 0);
    run_q("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
